// File: rtl/engine_pkg.sv
// Shared types and constants for the engine match collector.
package engine_pkg;

  // Packet collection phases: waiting for sod, inside packet, engine pipeline drain.
  typedef enum logic [1:0] {
    COLLECT_IDLE = 2'd0,
    ACTIVE       = 2'd1,
    DRAIN        = 2'd2
  } collect_state_t;

  // Report stream: idle, or emitting beats for one snapshot.
  typedef enum logic {
    R_IDLE = 1'b0,
    R_EMIT = 1'b1
  } report_state_t;

  // Last char flop + end-state flop inside each engine.
  localparam int DRAIN_CYC_DEF = 2;
  localparam int DROP_W        = 16;

endpackage

// File: rtl/lowest_set_encoder.sv
// Combinational priority encoder: index of the lowest set bit, plus
// any-set and exactly-one-set flags.
module lowest_set_encoder #(
  parameter int NUM_ENGINES = 16,
  parameter int ID_W        = 8
) (
  input  logic [NUM_ENGINES-1:0] vec,
  output logic [ID_W-1:0]        idx,
  output logic                   any,
  output logic                   only_one
);

  localparam logic [NUM_ENGINES-1:0] ONE = NUM_ENGINES'(1);

  // Scan high to low so the lowest set bit wins.
  always_comb begin
    idx = '0;
    for (int i = NUM_ENGINES - 1; i >= 0; i--) begin
      if (vec[i]) idx = ID_W'(i);
    end
  end

  assign any      = |vec;
  // Clearing the lowest set bit leaves nothing when only one bit is set.
  assign only_one = any && ((vec & (vec - ONE)) == '0);

endmodule

// File: rtl/engine_match_collector.sv
// Collects sticky engine match lines over one packet, snapshots them once the
// engine pipeline has drained, and streams the fired engine IDs lowest first.
module engine_match_collector
  import engine_pkg::*;
#(
  parameter int NUM_ENGINES = 16,
  parameter int ID_W        = 8,
  parameter int DRAIN_CYC   = DRAIN_CYC_DEF,
  parameter int PKT_W       = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sod,
  input  logic                   eod,
  input  logic                   en,
  input  logic [NUM_ENGINES-1:0] match_in,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [ID_W-1:0]        m_engine_id,
  output logic                   m_nomatch,
  output logic                   m_last,
  output logic [PKT_W-1:0]       m_pkt_no,
  output logic [DROP_W-1:0]      drop_cnt,
  output logic                   busy
);

  localparam int CNT_W = (DRAIN_CYC < 1) ? 1 : $clog2(DRAIN_CYC + 1);
  localparam logic [NUM_ENGINES-1:0] ONE = NUM_ENGINES'(1);

  collect_state_t c_state, c_next;
  report_state_t  r_state, r_next;

  logic [NUM_ENGINES-1:0] seen, snap, snap_val, enc_in, enc_rest;
  logic [CNT_W-1:0]       drain_cnt;
  logic [PKT_W-1:0]       pkt_cnt;
  logic [ID_W-1:0]        enc_idx;
  logic                   enc_any, enc_one;
  logic                   seen_clr, seen_acc, cnt_load, cnt_dec, snap_fire;
  logic                   load, drop, hs;

  assign snap_val = seen | match_in;
  assign hs       = m_valid & m_ready;
  assign busy     = (c_state != COLLECT_IDLE) || (r_state != R_IDLE);

  // One encoder serves both the first beat (fresh snapshot) and later beats
  // (remaining bits); enc_rest is its input with the reported bit removed.
  assign enc_in   = load ? snap_val : snap;
  assign enc_rest = enc_in & (enc_in - ONE);

  lowest_set_encoder #(
    .NUM_ENGINES (NUM_ENGINES),
    .ID_W        (ID_W)
  ) u_enc (
    .vec      (enc_in),
    .idx      (enc_idx),
    .any      (enc_any),
    .only_one (enc_one)
  );

  // State registers for both FSMs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_state <= COLLECT_IDLE;
      r_state <= R_IDLE;
    end else begin
      c_state <= c_next;
      r_state <= r_next;
    end
  end

  // Collect next-state: sod always restarts (ignoring match_in that cycle,
  // engines are clearing); a sod during DRAIN silently aborts that packet.
  always_comb begin
    c_next    = c_state;
    seen_clr  = 1'b0;
    seen_acc  = 1'b0;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    snap_fire = 1'b0;
    if (sod) begin
      seen_clr = 1'b1;
      cnt_load = eod;
      c_next   = eod ? DRAIN : ACTIVE;
    end else begin
      case (c_state)
        ACTIVE: begin
          seen_acc = 1'b1;
          if (eod) begin
            cnt_load = 1'b1;
            c_next   = DRAIN;
          end
        end
        DRAIN: begin
          seen_acc = 1'b1;
          if (drain_cnt == '0) begin
            snap_fire = 1'b1;
            c_next    = COLLECT_IDLE;
          end else if (en) begin
            cnt_dec = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Report next-state: a snapshot is accepted only when the stream is idle.
  always_comb begin
    r_next = r_state;
    load   = 1'b0;
    drop   = 1'b0;
    case (r_state)
      R_IDLE: begin
        if (snap_fire) begin
          load   = 1'b1;
          r_next = R_EMIT;
        end
      end
      R_EMIT: begin
        drop = snap_fire;
        if (hs && m_last) r_next = R_IDLE;
      end
      default: ;
    endcase
  end

  // Collect datapath: accumulated matches, drain counter, packet and drop counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen      <= '0;
      drain_cnt <= '0;
      pkt_cnt   <= '0;
      drop_cnt  <= '0;
    end else begin
      if (seen_clr)      seen <= '0;
      else if (seen_acc) seen <= snap_val;
      if (cnt_load)      drain_cnt <= CNT_W'(DRAIN_CYC);
      else if (cnt_dec)  drain_cnt <= drain_cnt - CNT_W'(1);
      if (snap_fire)     pkt_cnt <= pkt_cnt + PKT_W'(1);
      if (drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + DROP_W'(1);
    end
  end

  // Registered beat outputs; held while stalled, advanced one bit per handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid     <= 1'b0;
      m_engine_id <= '0;
      m_nomatch   <= 1'b0;
      m_last      <= 1'b0;
      m_pkt_no    <= '0;
      snap        <= '0;
    end else if (load) begin
      m_valid     <= 1'b1;
      m_engine_id <= enc_idx;
      m_nomatch   <= !enc_any;
      m_last      <= !enc_any || enc_one;
      m_pkt_no    <= pkt_cnt;
      snap        <= enc_rest;
    end else if (hs) begin
      if (m_last) begin
        m_valid     <= 1'b0;
        m_engine_id <= '0;
        m_nomatch   <= 1'b0;
        m_last      <= 1'b0;
      end else begin
        m_engine_id <= enc_idx;
        m_last      <= enc_one;
        snap        <= enc_rest;
      end
    end
  end

endmodule

// File: tb/tb_engine_match_collector.sv
// Randomised and directed bench for engine_match_collector; expected beats
// come from the fired-engine set of each packet (ascending IDs, last on the top one).
module tb_engine_match_collector;

  localparam int NE = 16;
  localparam int DC = 2;

  typedef struct packed {
    logic [7:0]  id;
    logic        nm;
    logic        last;
    logic [15:0] pkt;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n, sod, eod, en, m_ready;
  logic [15:0] match_in;
  logic        m_valid, m_nomatch, m_last, busy;
  logic [7:0]  m_engine_id;
  logic [15:0] m_pkt_no, drop_cnt;

  int    checks = 0;
  int    errors = 0;
  int    stab_err = 0;
  int    exp_pkt = 0;
  int    ready_mode = 0;  // 0 always ready, 1 toggle, 2 held low, 3 random
  beat_t got_q[$];
  beat_t exp_q[$];
  beat_t cur_beat, prev_beat;
  bit    prev_stall;

  engine_match_collector #(.NUM_ENGINES(NE), .ID_W(8), .DRAIN_CYC(DC), .PKT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .sod(sod), .eod(eod), .en(en), .match_in(match_in),
    .m_valid(m_valid), .m_ready(m_ready), .m_engine_id(m_engine_id),
    .m_nomatch(m_nomatch), .m_last(m_last), .m_pkt_no(m_pkt_no),
    .drop_cnt(drop_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  assign cur_beat = {m_engine_id, m_nomatch, m_last, m_pkt_no};

  // Record accepted beats and flag any change of a stalled beat.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall && (!m_valid || cur_beat != prev_beat)) stab_err <= stab_err + 1;
      if (m_valid && m_ready) got_q.push_back(cur_beat);
      prev_stall <= m_valid && !m_ready;
      prev_beat  <= cur_beat;
    end
  end

  // Drive one cycle of inputs; returns at posedge+1.
  task automatic step(input logic s, input logic e, input logic v, input logic [15:0] m);
    sod = s; eod = e; en = v; match_in = m;
    case (ready_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = ~m_ready;
      2:       m_ready = 1'b0;
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, match_in);
  endtask

  task automatic wait_beats(input int n);
    for (int k = 0; k < 400 && got_q.size() < n; k++) idle(1);
  endtask

  // Reference: report of a fired set is its members ascending, last on the highest;
  // an empty set yields one no-match beat.
  task automatic add_exp(input logic [15:0] set, input int pkt);
    if (set == 16'h0) exp_q.push_back({8'd0, 1'b1, 1'b1, 16'(pkt)});
    else for (int i = 0; i < NE; i++)
      if (set[i]) exp_q.push_back({8'(i), 1'b0, ((set >> (i + 1)) == 16'h0), 16'(pkt)});
  endtask

  // Packet whose engines end up with exactly `fin` fired; bits rise at random
  // points, the final value present on the last drain en-cycle and snapshot cycle.
  task automatic send_pkt(input logic [15:0] fin, input int nbytes, input bit gaps);
    logic [15:0] m;
    int ens;
    m = 16'h0;
    step(1'b1, nbytes == 1, 1'b1, match_in);  // stale lines from the previous packet
    for (int b = 2; b <= nbytes; b++) begin
      if (gaps) while ($urandom_range(0, 3) == 0) step(1'b0, 1'b0, 1'b0, m);
      m |= fin & 16'($urandom);
      step(1'b0, b == nbytes, 1'b1, m);
    end
    ens = 0;
    while (ens < DC) begin
      if (gaps && $urandom_range(0, 2) == 0) step(1'b0, 1'b0, 1'b0, m);
      else begin
        ens++;
        m = (ens == DC) ? fin : (m | (fin & 16'($urandom)));
        step(1'b0, 1'b0, 1'b1, m);
      end
    end
    step(1'b0, 1'b0, 1'($urandom_range(0, 1)), fin);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sod = 0; eod = 0; en = 0; match_in = '0; m_ready = 0; ready_mode = 0;
    repeat (3) @(posedge clk); #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", m_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    checks++; if (drop_cnt !== 16'h0) begin errors++; $display("FAIL rst_drop got %h exp 0", drop_cnt); end
    checks++; if (cur_beat !== beat_t'(0)) begin errors++; $display("FAIL rst_beat got %h exp 0", cur_beat); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    step(1'b0, 1'b1, 1'b1, 16'h0);  // eod without sod: ignored
    idle(1);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stray_eod_busy got %b exp 0", busy); end
  endtask

  task automatic test_basic();
    beat_t g;
    ready_mode = 0;
    step(1'b1, 1'b0, 1'b1, 16'hFFFF);  // stale lines on sod must be ignored
    for (int b = 2; b <= 10; b++) step(1'b0, b == 10, 1'b1, (b >= 6) ? 16'h0008 : 16'h0000);
    step(1'b0, 1'b0, 1'b1, 16'h0008);
    step(1'b0, 1'b0, 1'b1, 16'h0208);  // engine 9 fires in the drain window
    step(1'b0, 1'b0, 1'b0, 16'h0208);
    add_exp(16'h0208, exp_pkt); exp_pkt++;
    wait_beats(exp_q.size());
    idle(2);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL basic_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      g = (i < got_q.size()) ? got_q[i] : beat_t'(0);
      checks++; if (g !== exp_q[i]) begin errors++; $display("FAIL basic_beat%0d got %h exp %h", i, g, exp_q[i]); end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy got %b exp 0", busy); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_nomatch();
    beat_t g;
    ready_mode = 0;
    send_pkt(16'h0000, 5, 1'b0);
    add_exp(16'h0000, exp_pkt); exp_pkt++;
    wait_beats(exp_q.size()); idle(2);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL nomatch_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      g = (i < got_q.size()) ? got_q[i] : beat_t'(0);
      checks++; if (g !== exp_q[i]) begin errors++; $display("FAIL nomatch_beat%0d got %h exp %h", i, g, exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_stall();
    beat_t g;
    int se;
    se = stab_err;
    ready_mode = 1;
    send_pkt(16'h8021, 6, 1'b1);
    add_exp(16'h8021, exp_pkt); exp_pkt++;
    wait_beats(exp_q.size()); idle(2);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL stall_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      g = (i < got_q.size()) ? got_q[i] : beat_t'(0);
      checks++; if (g !== exp_q[i]) begin errors++; $display("FAIL stall_beat%0d got %h exp %h", i, g, exp_q[i]); end
    end
    checks++; if (stab_err != se) begin errors++; $display("FAIL stall_stable got %0d changes exp 0", stab_err - se); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_drop();
    beat_t g;
    ready_mode = 2;
    send_pkt(16'h0084, 4, 1'b0);
    add_exp(16'h0084, exp_pkt); exp_pkt++;
    for (int k = 0; k < 20 && !m_valid; k++) idle(1);
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL drop_first_valid got %b exp 1", m_valid); end
    send_pkt(16'h0002, 3, 1'b0);  // finishes while the first report is stalled
    exp_pkt++;
    idle(1);
    checks++; if (drop_cnt !== 16'd1) begin errors++; $display("FAIL drop_cnt got %0d exp 1", drop_cnt); end
    ready_mode = 0;
    send_pkt(16'h0010, 5, 1'b0);
    add_exp(16'h0010, exp_pkt); exp_pkt++;
    wait_beats(exp_q.size()); idle(2);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL drop_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      g = (i < got_q.size()) ? got_q[i] : beat_t'(0);
      checks++; if (g !== exp_q[i]) begin errors++; $display("FAIL drop_beat%0d got %h exp %h", i, g, exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  // sod+eod single-byte packet; engine 0 fires on the second drain en-cycle,
  // after `stall` en=0 cycles. lat counts cycles until m_valid rises.
  task automatic one_byte(input int stall, output int lat);
    int ens;
    ens = 0; lat = 0;
    step(1'b1, 1'b1, 1'b1, match_in);
    for (int k = 0; k < 30; k++) begin
      logic v;
      v = (k == 0) || (k == stall + 1);
      if (v) ens++;
      step(1'b0, 1'b0, v, (ens >= 2) ? 16'h0001 : 16'h0000);
      lat++;
      if (m_valid) break;
    end
  endtask

  task automatic test_one_byte();
    beat_t g;
    int lat0, lat1;
    ready_mode = 0;
    one_byte(0, lat0);
    add_exp(16'h0001, exp_pkt); exp_pkt++;
    wait_beats(exp_q.size()); idle(2);
    one_byte(3, lat1);
    add_exp(16'h0001, exp_pkt); exp_pkt++;
    wait_beats(exp_q.size()); idle(2);
    checks++; if (lat1 - lat0 != 3) begin errors++; $display("FAIL onebyte_stall_delay got %0d exp 3", lat1 - lat0); end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL onebyte_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      g = (i < got_q.size()) ? got_q[i] : beat_t'(0);
      checks++; if (g !== exp_q[i]) begin errors++; $display("FAIL onebyte_beat%0d got %h exp %h", i, g, exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    beat_t g;
    logic [15:0] fin;
    int se;
    se = stab_err;
    ready_mode = 3;
    for (int p = 0; p < 20; p++) begin
      fin = ($urandom_range(0, 4) == 0) ? 16'h0 : (16'($urandom) & 16'($urandom));
      send_pkt(fin, $urandom_range(1, 8), 1'b1);
      add_exp(fin, exp_pkt); exp_pkt++;
      wait_beats(exp_q.size()); idle(1);
    end
    idle(2);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      g = (i < got_q.size()) ? got_q[i] : beat_t'(0);
      checks++; if (g !== exp_q[i]) begin errors++; $display("FAIL rand_beat%0d got %h exp %h", i, g, exp_q[i]); end
    end
    checks++; if (stab_err != se) begin errors++; $display("FAIL rand_stable got %0d changes exp 0", stab_err - se); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid();
    beat_t g;
    ready_mode = 2;
    send_pkt(16'h0030, 3, 1'b0);
    for (int k = 0; k < 20 && !m_valid; k++) idle(1);
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL rmid_valid_before got %b exp 1", m_valid); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b exp 0", m_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b exp 0", busy); end
    checks++; if (drop_cnt !== 16'h0) begin errors++; $display("FAIL rmid_drop got %0d exp 0", drop_cnt); end
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    got_q.delete(); exp_q.delete();
    exp_pkt = 0;
    ready_mode = 0;
    send_pkt(16'h0100, 4, 1'b1);
    add_exp(16'h0100, exp_pkt); exp_pkt++;
    wait_beats(exp_q.size()); idle(2);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rmid_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      g = (i < got_q.size()) ? got_q[i] : beat_t'(0);
      checks++; if (g !== exp_q[i]) begin errors++; $display("FAIL rmid_beat%0d got %h exp %h", i, g, exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_nomatch();
    test_stall();
    test_drop();
    test_one_byte();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
